db_ram_rd_stream: RTL
=====================

# db_ram_rd_stream

Read-side streaming controller for the deblocking dual-port SRAMs: on `start_i` it reads `len_i` consecutive 128-bit words from port B of the 128x256 SRAM and presents them as a valid/ready stream. It sits directly downstream of the SRAM and feeds the fetch/write-back stage. A small FIFO absorbs the SRAM's one-cycle read latency, so the stream can stall arbitrarily while the SRAM still runs at one word per cycle.

## Interface
- `WORD_W`, 128: SRAM word / stream data width.
- `ADDR_W`, 8: SRAM address width (256 words).
- `FIFO_D`, 3: data FIFO depth. 3 is the minimum for full throughput.
- `clk` in, 1: single clock. All logic is clocked on the rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `start_i` in, 1: starts a burst. Sampled only while `busy_o` is 0.
- `base_addr_i` in, ADDR_W: first SRAM address, sampled with `start_i`.
- `len_i` in, 9: word count 0..256. Values above 256 are clamped to 256.
- `busy_o` out, 1: burst in progress.
- `done_o` out, 1: one-cycle pulse when the burst completes.
- `cenb_o` out, 1: SRAM chip enable, active low.
- `oenb_o` out, 1: SRAM output enable, active low. Always equal to `cenb_o`.
- `wenb_o` out, 1: SRAM write enable, active low. Tied to 1 (read only).
- `addrb_o` out, ADDR_W: SRAM read address.
- `datab_i` in, WORD_W: SRAM read data. Valid in the cycle after a read is issued.
- `data_o` out, WORD_W: stream data.
- `valid_o` out, 1: stream data valid.
- `ready_i` in, 1: downstream accept.
- `last_o` out, 1: marks the final word of the burst. Qualified by `valid_o`.

## Operation
- States:
  - IDLE: `start_i` with `len` ≠ 0 → READ. `start_i` with `len` = 0 → DONE.
  - READ: moves to DRAIN once `len` reads have been issued.
  - DRAIN: moves to DONE on the handshake (`valid_o && ready_i`) of the last word.
  - DONE: one cycle, then → IDLE.
- Issue rule: in READ, a read is issued (`cenb_o` = 0) when `fifo_cnt + inflight < FIFO_D`.
  - `inflight` is a 1-bit register: 1 if a read was issued in the previous cycle.
  - `cenb_o` is decoded from registered state only. It has no combinational path from `ready_i`.
- Address: `addrb_o = base + issued_cnt`, truncated to ADDR_W, so it wraps 0xFF → 0x00.
- Capture: when `inflight` = 1, `datab_i` is pushed into the FIFO that cycle.
  - FIFO push and pop may happen in the same cycle.
  - The issue rule guarantees the FIFO never overflows.
- Stream outputs:
  - `valid_o` = FIFO not empty; `data_o` = FIFO head.
  - `last_o` = 1 when the head is word number `len−1`, tracked by a popped-word counter.
- `start_i` while `busy_o` = 1 is ignored; no state changes.
- `len` is 9 bits, so `len` = 256 reads the whole SRAM once.
- `busy_o` = 1 in READ, DRAIN and DONE.
- `done_o` = 1 only in DONE.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `valid_o`, `last_o` = 0.
  - `cenb_o`, `oenb_o`, `wenb_o` = 1.
  - `addrb_o`, `data_o` = 0.
  - FIFO empty; counters 0.
- `rst` mid-burst: outputs go to reset values immediately (asynchronous). Buffered data is discarded and no `done_o` pulse is produced.
- Latency, with `start_i` sampled at the end of cycle T:
  - First read (`cenb_o` = 0) in T+1.
  - `datab_i` valid in T+2.
  - `valid_o` = 1 in T+3.
- Throughput: with `ready_i` held high, one word per cycle.
  - `n`-word burst: last handshake in T+2+n, `done_o` in T+3+n.
- `len` = 0: `done_o` pulses in T+1. No SRAM access, no stream beats.
- Back-to-back bursts: a new `start_i` can be accepted in the cycle after `done_o`.

## Configuration
- `DB_RD_STALL_CNT_EN` defined:
  - Adds output `stall_cnt_o` [15:0].
  - The counter increments in each cycle with `valid_o && !ready_i`, saturates at 0xFFFF, and clears on an accepted `start_i` and on `rst`.
- `DB_RD_STALL_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package (`enc_defines.v` scope):
  - `DB_WORD_W` = 128 and `DB_ADDR_W` = 8.
  - FSM state encoding: IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3.
- Sub-module `db_rd_fifo`: synchronous register FIFO, parameterised by width and depth.
  - Ports: push, pop, data in, head out, count, empty.
- Top level: FSM, issue/pop counters and address generation.

## Test plan
- Basic burst: base=0x10, len=4, `ready_i`=1, SRAM[a]=a → `cenb_o` low T+1..T+4; `data_o` 0x10..0x13 in T+3..T+6; `last_o` with 0x13; `done_o` at T+7.
- Backpressure: len=8, `ready_i` toggles 1/0 each cycle.
  - Words 0..7 are delivered in order, none lost or duplicated.
  - `cenb_o` is never low while `fifo_cnt + inflight` = 3.
- Wrap-around: base=0xFE, len=4 → addresses 0xFE, 0xFF, 0x00, 0x01. len=300 → exactly 256 words.
- Zero length and busy: len=0 → `done_o` in T+1, `cenb_o` stays 1. A second `start_i` during a burst leaves counters and `addrb_o` unchanged.
- Reset mid-burst: assert `rst` after 3 of 8 words → all outputs at reset values in the same cycle, no `done_o`. A new burst then runs correctly.
- With `DB_RD_STALL_CNT_EN`: len=2, `ready_i`=0 for 5 cycles after `valid_o` rises → `stall_cnt_o` = 5.

Source files
------------

// File: rtl/db_ram_rd_stream_pkg.sv
// Shared definitions for the deblocking SRAM read-stream controller:
// word/address widths, burst length limits and the FSM state encoding.
package db_ram_rd_stream_pkg;

    localparam int DB_WORD_W  = 128;
    localparam int DB_ADDR_W  = 8;
    localparam int DB_LEN_W   = 9;
    localparam int DB_MAX_LEN = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Requested lengths above one full SRAM pass are limited to a single pass.
    function automatic logic [DB_LEN_W-1:0] clamp_len(input logic [DB_LEN_W-1:0] len);
        return (len > DB_LEN_W'(DB_MAX_LEN)) ? DB_LEN_W'(DB_MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/db_ram_rd_stream_fifo.sv
// db_rd_fifo: small synchronous register FIFO. The head is always visible on
// head_o; push and pop may occur in the same cycle. The caller guarantees no
// push while full and no pop while empty.
module db_rd_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             din_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy update.
    // NOTE: the storage is reset too: it is only a few words and it makes the
    // head read back as zero after reset instead of stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/db_ram_rd_stream.sv
// db_ram_rd_stream: streams len_i consecutive words out of SRAM port B as a
// valid/ready stream. A FIFO of FIFO_D words absorbs the one-cycle SRAM read
// latency; reads are only issued when the FIFO is guaranteed to have room.
// Optional feature: define DB_RD_STALL_CNT_EN to add the stall_cnt_o counter.
module db_ram_rd_stream
    import db_ram_rd_stream_pkg::*;
#(
    parameter int WORD_W = DB_WORD_W,
    parameter int ADDR_W = DB_ADDR_W,
    parameter int FIFO_D = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [8:0]        len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cenb_o,
    output logic              oenb_o,
    output logic              wenb_o,
    output logic [ADDR_W-1:0] addrb_o,
    input  logic [WORD_W-1:0] datab_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o
`ifdef DB_RD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_D + 1);

    rd_state_e         state_q, state_d;
    logic [8:0]        len_q, len_d;
    logic [8:0]        issued_q, issued_d;
    logic [8:0]        popped_q, popped_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              inflight_q;

    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W:0]    occupancy;
    logic              fifo_empty;
    logic              issue;
    logic              pop;

    // Words already committed to the FIFO: stored ones plus the read in flight.
    assign occupancy = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
    // Decoded from registered state only, so ready_i never reaches the SRAM.
    assign issue     = (state_q == ST_READ) && (occupancy < (CNT_W + 1)'(FIFO_D));
    assign pop       = valid_o && ready_i;

    db_rd_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (datab_i),
        .head_o  (data_o),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign last_o  = valid_o && (popped_q == len_q - 9'd1);
    assign cenb_o  = !issue;
    assign oenb_o  = cenb_o;
    assign wenb_o  = 1'b1;
    assign addrb_o = base_q + ADDR_W'(issued_q);
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);

    // Next-state and counter logic for the burst FSM.
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        base_d   = base_q;

        if (pop) popped_d = popped_q + 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d    = clamp_len(len_i);
                    base_d   = base_addr_i;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (clamp_len(len_i) == 9'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    issued_d = issued_q + 9'd1;
                    if (issued_q + 9'd1 == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && last_o) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values of the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            base_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            base_q     <= base_d;
            inflight_q <= issue;
        end
    end

`ifdef DB_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where the stream is held off by downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (start_i && state_q == ST_IDLE) begin
            stall_cnt_q <= '0;
        end else if (valid_o && !ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
